// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch-type encodings, condition codes, FSM states, default widths.
package cpu_pkg;

  localparam int unsigned PC_WIDTH_DEF     = 32;
  localparam int unsigned OFFSET_WIDTH_DEF = 19;
  localparam int unsigned STAT_WIDTH       = 16;

  localparam logic [1:0] BR_COND = 2'b00;
  localparam logic [1:0] BR_JR   = 2'b01;
  localparam logic [1:0] BR_JAL  = 2'b10;
  localparam logic [1:0] BR_RSVD = 2'b11;

  // Condition codes as carried in the IR C2 field feeding the CON flip-flop
  localparam logic [1:0] CC_ZERO    = 2'b00;
  localparam logic [1:0] CC_NONZERO = 2'b01;
  localparam logic [1:0] CC_POS     = 2'b10;
  localparam logic [1:0] CC_NEG     = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_CON = 2'd1,
    ST_COMMIT   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SEL_HOLD = 2'd0,
    SEL_INC  = 2'd1,
    SEL_BR   = 2'd2,
    SEL_RB   = 2'd3
  } pc_sel_e;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC mux: hold, increment, PC-relative branch, register target.
module pc_target_calc
  import cpu_pkg::*;
#(
  parameter int unsigned PC_WIDTH     = PC_WIDTH_DEF,
  parameter int unsigned OFFSET_WIDTH = OFFSET_WIDTH_DEF
) (
  input  logic [PC_WIDTH-1:0]     pc,
  input  logic [OFFSET_WIDTH-1:0] offset,
  input  logic [PC_WIDTH-1:0]     rb_value,
  input  logic [1:0]              sel,
  output logic [PC_WIDTH-1:0]     next_pc_c
);

  logic [PC_WIDTH-1:0] offset_ext;

  assign offset_ext = {{(PC_WIDTH - OFFSET_WIDTH){offset[OFFSET_WIDTH-1]}}, offset};

  // All sums wrap modulo 2^PC_WIDTH
  always_comb begin
    next_pc_c = pc;
    case (pc_sel_e'(sel))
      SEL_INC:  next_pc_c = pc + PC_WIDTH'(1);
      SEL_BR:   next_pc_c = pc + offset_ext;
      SEL_RB:   next_pc_c = rb_value;
      default:  next_pc_c = pc;
    endcase
  end

endmodule

// File: rtl/branch_pc_seq.sv
// PC sequencer: increment, conditional branch on CON, jr and jal with link strobe.
// Optional BRANCH_STATS_EN adds saturating taken/not-taken counters for conditional branches.
module branch_pc_seq
  import cpu_pkg::*;
#(
  parameter int unsigned         PC_WIDTH     = PC_WIDTH_DEF,
  parameter int unsigned         OFFSET_WIDTH = OFFSET_WIDTH_DEF,
  parameter logic [PC_WIDTH-1:0] RESET_PC     = '0
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    pc_inc,
  input  logic                    br_req,
  input  logic [1:0]              br_type,
  input  logic [OFFSET_WIDTH-1:0] offset,
  input  logic [PC_WIDTH-1:0]     rb_value,
  input  logic                    con_in,
  input  logic                    con_valid,
`ifdef BRANCH_STATS_EN
  output logic [STAT_WIDTH-1:0]   taken_cnt,
  output logic [STAT_WIDTH-1:0]   not_taken_cnt,
`endif
  output logic [PC_WIDTH-1:0]     pc_out,
  output logic [PC_WIDTH-1:0]     link_out,
  output logic                    link_we,
  output logic                    busy,
  output logic                    done,
  output logic                    taken
);

  state_e                  state_q, state_d;
  logic [1:0]              type_q, type_d;
  logic [OFFSET_WIDTH-1:0] offset_q, offset_d;
  logic [PC_WIDTH-1:0]     rb_q, rb_d;
  logic                    cond_q, cond_d;
  logic [PC_WIDTH-1:0]     pc_d, link_d;
  logic                    link_we_d, busy_d, done_d, taken_d;
  pc_sel_e                 pc_sel;
`ifdef BRANCH_STATS_EN
  logic [STAT_WIDTH-1:0]   taken_cnt_d, not_taken_cnt_d;
`endif

  // Operands are captured at request time so COMMIT does not depend on live inputs
  pc_target_calc #(
    .PC_WIDTH     (PC_WIDTH),
    .OFFSET_WIDTH (OFFSET_WIDTH)
  ) u_calc (
    .pc        (pc_out),
    .offset    (offset_q),
    .rb_value  (rb_q),
    .sel       (2'(pc_sel)),
    .next_pc_c (pc_d)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= ST_IDLE;
      type_q   <= BR_COND;
      offset_q <= '0;
      rb_q     <= '0;
      cond_q   <= 1'b0;
      pc_out   <= RESET_PC;
      link_out <= '0;
      link_we  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      taken    <= 1'b0;
`ifdef BRANCH_STATS_EN
      taken_cnt     <= '0;
      not_taken_cnt <= '0;
`endif
    end else begin
      state_q  <= state_d;
      type_q   <= type_d;
      offset_q <= offset_d;
      rb_q     <= rb_d;
      cond_q   <= cond_d;
      pc_out   <= pc_d;
      link_out <= link_d;
      link_we  <= link_we_d;
      busy     <= busy_d;
      done     <= done_d;
      taken    <= taken_d;
`ifdef BRANCH_STATS_EN
      taken_cnt     <= taken_cnt_d;
      not_taken_cnt <= not_taken_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    offset_d  = offset_q;
    rb_d      = rb_q;
    cond_d    = cond_q;
    pc_sel    = SEL_HOLD;
    link_d    = link_out;
    link_we_d = 1'b0;
    done_d    = 1'b0;
    taken_d   = taken;
`ifdef BRANCH_STATS_EN
    taken_cnt_d     = taken_cnt;
    not_taken_cnt_d = not_taken_cnt;
`endif

    case (state_q)
      ST_IDLE: begin
        if (br_req) begin
          type_d   = br_type;
          offset_d = offset;
          rb_d     = rb_value;
          case (br_type)
            BR_COND:       state_d = ST_WAIT_CON;
            BR_JR, BR_JAL: state_d = ST_COMMIT;
            default: begin
              // Reserved type completes as a no-op
              done_d  = 1'b1;
              taken_d = 1'b0;
            end
          endcase
        end else if (pc_inc) begin
          pc_sel = SEL_INC;
        end
      end

      ST_WAIT_CON: begin
        if (con_valid) begin
          cond_d  = con_in;
          state_d = ST_COMMIT;
        end
      end

      ST_COMMIT: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        case (type_q)
          BR_COND: begin
            taken_d = cond_q;
            pc_sel  = cond_q ? SEL_BR : SEL_HOLD;
`ifdef BRANCH_STATS_EN
            if (cond_q) begin
              if (taken_cnt != '1) taken_cnt_d = taken_cnt + STAT_WIDTH'(1);
            end else begin
              if (not_taken_cnt != '1) not_taken_cnt_d = not_taken_cnt + STAT_WIDTH'(1);
            end
`endif
          end
          BR_JR: begin
            taken_d = 1'b1;
            pc_sel  = SEL_RB;
          end
          BR_JAL: begin
            taken_d   = 1'b1;
            pc_sel    = SEL_RB;
            link_d    = pc_out;
            link_we_d = 1'b1;
          end
          default: pc_sel = SEL_HOLD;
        endcase
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_branch_pc_seq.sv
// Directed self-checking bench for branch_pc_seq (RESET_PC = 0x100).
module tb_branch_pc_seq;

  logic        clk = 1'b0;
  logic        clr;
  logic        pc_inc, br_req, con_in, con_valid;
  logic [1:0]  br_type;
  logic [18:0] offset;
  logic [31:0] rb_value;
  logic [31:0] pc_out, link_out;
  logic        link_we, busy, done, taken;
`ifdef BRANCH_STATS_EN
  logic [15:0] taken_cnt, not_taken_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  branch_pc_seq #(
    .PC_WIDTH     (32),
    .OFFSET_WIDTH (19),
    .RESET_PC     (32'h100)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .pc_inc    (pc_inc),
    .br_req    (br_req),
    .br_type   (br_type),
    .offset    (offset),
    .rb_value  (rb_value),
    .con_in    (con_in),
    .con_valid (con_valid),
`ifdef BRANCH_STATS_EN
    .taken_cnt     (taken_cnt),
    .not_taken_cnt (not_taken_cnt),
`endif
    .pc_out    (pc_out),
    .link_out  (link_out),
    .link_we   (link_we),
    .busy      (busy),
    .done      (done),
    .taken     (taken)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: jump to a known PC via jr (two cycles)
  task automatic go_jr(input logic [31:0] t);
    br_req = 1'b1; br_type = 2'b01; rb_value = t;
    tick();
    br_req = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    clr = 1'b1; pc_inc = 0; br_req = 0; br_type = 0; offset = 0;
    rb_value = 0; con_in = 0; con_valid = 0;
    tick(); tick();
    n_checks++; if (pc_out !== 32'h100) begin n_fail++; $display("FAIL reset_pc got %h want 00000100", pc_out); end
    n_checks++; if (link_out !== 32'h0) begin n_fail++; $display("FAIL reset_link got %h want 0", link_out); end
    n_checks++; if ({link_we, busy, done, taken} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got %b want 0000", {link_we, busy, done, taken}); end
`ifdef BRANCH_STATS_EN
    n_checks++; if ({taken_cnt, not_taken_cnt} !== 32'h0) begin n_fail++; $display("FAIL reset_stats got %h want 0", {taken_cnt, not_taken_cnt}); end
`endif
    clr = 1'b0;
    tick();
  endtask

  task automatic test_jr();
    br_req = 1'b1; br_type = 2'b01; rb_value = 32'h20;
    tick();
    br_req = 1'b0; rb_value = 32'hDEAD;
    n_checks++; if ({busy, done, pc_out} !== {1'b1, 1'b0, 32'h100}) begin n_fail++; $display("FAIL jr_cycle1 got busy=%b done=%b pc=%h want 1 0 00000100", busy, done, pc_out); end
    tick();
    n_checks++; if ({busy, done, taken, pc_out} !== {3'b011, 32'h20}) begin n_fail++; $display("FAIL jr_commit got busy=%b done=%b taken=%b pc=%h want 0 1 1 00000020", busy, done, taken, pc_out); end
    tick();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL jr_done_pulse got %b want 0", done); end
  endtask

  task automatic test_cond_taken();
    int busy_cycles = 0;
    br_req = 1'b1; br_type = 2'b00; offset = 19'h7FFFC; pc_inc = 1'b1;
    tick(); busy_cycles += int'(busy);
    br_req = 1'b0;
    tick(); busy_cycles += int'(busy);
    tick(); busy_cycles += int'(busy);
    n_checks++; if (pc_out !== 32'h20) begin n_fail++; $display("FAIL cond_wait_pc got %h want 00000020", pc_out); end
    con_valid = 1'b1; con_in = 1'b1; pc_inc = 1'b0;
    tick(); busy_cycles += int'(busy);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL cond_early_done got %b want 0", done); end
    con_valid = 1'b0; con_in = 1'b0;
    tick(); busy_cycles += int'(busy);
    n_checks++; if ({done, taken, pc_out} !== {2'b11, 32'h1C}) begin n_fail++; $display("FAIL cond_taken got done=%b taken=%b pc=%h want 1 1 0000001c", done, taken, pc_out); end
    n_checks++; if (busy_cycles !== 4) begin n_fail++; $display("FAIL cond_busy_cycles got %0d want 4", busy_cycles); end
    tick();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL cond_done_pulse got %b want 0", done); end
  endtask

  task automatic test_cond_not_taken();
    go_jr(32'h20);
    br_req = 1'b1; br_type = 2'b00; offset = 19'h00010;
    con_valid = 1'b1; con_in = 1'b0;
    tick();
    br_req = 1'b0;
    tick();
    con_valid = 1'b0;
    tick();
    n_checks++; if ({done, taken, pc_out} !== {2'b10, 32'h20}) begin n_fail++; $display("FAIL cond_not_taken got done=%b taken=%b pc=%h want 1 0 00000020", done, taken, pc_out); end
  endtask

  task automatic test_jal();
    go_jr(32'h44);
    tick();
    br_req = 1'b1; br_type = 2'b10; rb_value = 32'h200;
    tick();
    br_req = 1'b0;
    n_checks++; if ({done, link_we} !== 2'b00) begin n_fail++; $display("FAIL jal_cycle1 got done=%b link_we=%b want 0 0", done, link_we); end
    tick();
    n_checks++; if ({done, link_we, link_out, pc_out} !== {2'b11, 32'h44, 32'h200}) begin n_fail++; $display("FAIL jal_commit got done=%b we=%b link=%h pc=%h want 1 1 00000044 00000200", done, link_we, link_out, pc_out); end
    tick();
    n_checks++; if ({link_we, link_out} !== {1'b0, 32'h44}) begin n_fail++; $display("FAIL jal_after got we=%b link=%h want 0 00000044", link_we, link_out); end
  endtask

  task automatic test_wrap();
    go_jr(32'hFFFF_FFFF);
    pc_inc = 1'b1;
    tick();
    pc_inc = 1'b0;
    n_checks++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL inc_wrap got %h want 00000000", pc_out); end
    br_req = 1'b1; br_type = 2'b01; rb_value = 32'h10; pc_inc = 1'b1;
    tick();
    br_req = 1'b0; pc_inc = 1'b0;
    n_checks++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL req_beats_inc got %h want 00000000", pc_out); end
    tick();
    n_checks++; if (pc_out !== 32'h10) begin n_fail++; $display("FAIL req_beats_inc_commit got %h want 00000010", pc_out); end
    br_req = 1'b1; br_type = 2'b00; offset = 19'h7FFE0; con_valid = 1'b1; con_in = 1'b1;
    tick();
    br_req = 1'b0;
    tick(); tick();
    con_valid = 1'b0;
    n_checks++; if (pc_out !== 32'hFFFF_FFF0) begin n_fail++; $display("FAIL neg_wrap got %h want fffffff0", pc_out); end
  endtask

  task automatic test_reserved();
    br_req = 1'b1; br_type = 2'b11; rb_value = 32'h555;
    tick();
    br_req = 1'b0;
    n_checks++; if ({done, busy, taken, pc_out} !== {3'b100, 32'hFFFF_FFF0}) begin n_fail++; $display("FAIL reserved got done=%b busy=%b taken=%b pc=%h want 1 0 0 fffffff0", done, busy, taken, pc_out); end
    tick();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reserved_pulse got %b want 0", done); end
  endtask

  task automatic test_clr_mid();
    go_jr(32'h300);
    br_req = 1'b1; br_type = 2'b00; offset = 19'h00004;
    tick();
    br_req = 1'b0;
    #2 clr = 1'b1;
    #1;
    n_checks++; if ({busy, pc_out} !== {1'b0, 32'h100}) begin n_fail++; $display("FAIL clr_async got busy=%b pc=%h want 0 00000100", busy, pc_out); end
    con_valid = 1'b1; con_in = 1'b1;
    tick();
    clr = 1'b0;
    tick(); tick();
    con_valid = 1'b0;
    n_checks++; if ({done, busy, pc_out} !== {2'b00, 32'h100}) begin n_fail++; $display("FAIL clr_abort got done=%b busy=%b pc=%h want 0 0 00000100", done, busy, pc_out); end
  endtask

`ifdef BRANCH_STATS_EN
  task automatic test_stats_saturate();
    int ndone = 0;
    int budget = 0;
    br_req = 1'b1; br_type = 2'b00; offset = 19'h0; con_valid = 1'b1; con_in = 1'b1;
    while (ndone < 70000 && budget < 300000) begin
      tick();
      budget++;
      if (done) ndone++;
    end
    br_req = 1'b0; con_valid = 1'b0;
    tick(); tick(); tick();
    n_checks++; if (ndone !== 70000) begin n_fail++; $display("FAIL stats_budget got %0d commits want 70000", ndone); end
    n_checks++; if ({taken_cnt, not_taken_cnt} !== {16'hFFFF, 16'h0}) begin n_fail++; $display("FAIL stats_sat got %h %h want ffff 0000", taken_cnt, not_taken_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_jr();
    test_cond_taken();
    test_cond_not_taken();
    test_jal();
    test_wrap();
    test_reserved();
    test_clr_mid();
`ifdef BRANCH_STATS_EN
    test_stats_saturate();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
